// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter.
package updown_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // One guard bit so C+STEP and C+MAX_VAL+1 cannot overflow.
    function automatic int sum_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count logic: one step up or down with wrap or saturate.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (2**WIDTH) - 1,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0] c,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] c_next,
    output logic             hit
);

    localparam int SW = sum_width(WIDTH);
    localparam logic [SW-1:0] MAX_EXT  = SW'(MAX_VAL);
    localparam logic [SW-1:0] STEP_EXT = SW'(STEP);
    localparam logic [SW-1:0] MOD_EXT  = SW'(MAX_VAL + 1);

    logic [SW-1:0]    c_ext;
    logic [SW-1:0]    sum_up;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] diff_dn;
    logic [WIDTH-1:0] wrap_dn;

    assign c_ext   = {1'b0, c};
    assign sum_up  = c_ext + STEP_EXT;
    assign wrap_up = WIDTH'(sum_up - MOD_EXT);
    assign diff_dn = WIDTH'(c_ext - STEP_EXT);
    assign wrap_dn = WIDTH'(c_ext + MOD_EXT - STEP_EXT);

    always_comb begin
        c_next = c;
        hit    = 1'b0;
        if (up == DIR_UP) begin
            if (sum_up <= MAX_EXT) begin
                c_next = sum_up[WIDTH-1:0];
            end else if (sat == MODE_WRAP) begin
                c_next = wrap_up;
                hit    = 1'b1;
            end else begin
                c_next = MAX_EXT[WIDTH-1:0];
                hit    = (c_ext != MAX_EXT);
            end
        end else begin
            if (c_ext >= STEP_EXT) begin
                c_next = diff_dn;
            end else if (sat == MODE_WRAP) begin
                c_next = wrap_dn;
                hit    = 1'b1;
            end else begin
                c_next = '0;
                hit    = (c != '0);
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with step, wrap/saturate mode and parallel load.
// Optional capture register enabled by UPDOWN_COUNTER_CAPTURE_EN.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (2**WIDTH) - 1,
    parameter int STEP    = 1
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             EN,
    input  logic             UP,
    input  logic             SAT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] C,
    output logic             TC,
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    output logic             WRAP,
    input  logic             CAP,
    output logic [WIDTH-1:0] CAP_VAL
`else
    output logic             WRAP
`endif
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] c_next;
    logic             hit;
    logic [WIDTH-1:0] load_clamped;

    updown_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_next (
        .c      (C),
        .up     (UP),
        .sat    (SAT),
        .c_next (c_next),
        .hit    (hit)
    );

    // A full-range counter cannot see an out-of-range load, so no clamp there.
    generate
        if (MAX_VAL < (2**WIDTH) - 1) begin : g_clamp
            assign load_clamped = (LOAD_VAL > MAX_C) ? MAX_C : LOAD_VAL;
        end else begin : g_noclamp
            assign load_clamped = LOAD_VAL;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RES) begin
            C    <= '0;
            WRAP <= 1'b0;
        end else if (LOAD) begin
            C    <= load_clamped;
            WRAP <= 1'b0;
        end else if (EN) begin
            C    <= c_next;
            WRAP <= hit;
        end else begin
            WRAP <= 1'b0;
        end
    end

    assign TC = ((UP == DIR_UP) && (C == MAX_C)) || ((UP == DIR_DOWN) && (C == '0));

`ifdef UPDOWN_COUNTER_CAPTURE_EN
    // Captures the pre-update count of the same edge.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            CAP_VAL <= '0;
        end else if (CAP) begin
            CAP_VAL <= C;
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench: default 8-bit counter and a WIDTH=4/MAX=9/STEP=3 instance.
module tb_updown_counter;

    logic       clk;
    logic       res8, en8, up8, sat8, load8;
    logic [7:0] load_val8;
    logic [7:0] c8;
    logic       tc8, wrap8;
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    logic       cap8;
    logic [7:0] cap_val8;
`endif

    logic       res4, en4, up4, sat4, load4;
    logic [3:0] load_val4;
    logic [3:0] c4;
    logic       tc4, wrap4;
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    logic       cap4;
    logic [3:0] cap_val4;
`endif

    int n_err = 0;
    int n_checks = 0;
    int wrap_cnt;

    updown_counter u_dut8 (
        .CLK      (clk),
        .RES      (res8),
        .EN       (en8),
        .UP       (up8),
        .SAT      (sat8),
        .LOAD     (load8),
        .LOAD_VAL (load_val8),
        .C        (c8),
        .TC       (tc8),
`ifdef UPDOWN_COUNTER_CAPTURE_EN
        .WRAP     (wrap8),
        .CAP      (cap8),
        .CAP_VAL  (cap_val8)
`else
        .WRAP     (wrap8)
`endif
    );

    updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3)) u_dut4 (
        .CLK      (clk),
        .RES      (res4),
        .EN       (en4),
        .UP       (up4),
        .SAT      (sat4),
        .LOAD     (load4),
        .LOAD_VAL (load_val4),
        .C        (c4),
        .TC       (tc4),
`ifdef UPDOWN_COUNTER_CAPTURE_EN
        .WRAP     (wrap4),
        .CAP      (cap4),
        .CAP_VAL  (cap_val4)
`else
        .WRAP     (wrap4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected sequences for the 4-bit instance
    int seq_up_c[7]    = '{3, 6, 9, 2, 5, 8, 1};
    int seq_up_w[7]    = '{0, 0, 0, 1, 0, 0, 1};
    int seq_sat_c[4]   = '{4, 1, 0, 0};
    int seq_sat_w[4]   = '{0, 0, 1, 0};
    int seq_sat_tc[4]  = '{0, 0, 1, 1};
    int seq_dn_c[4]    = '{6, 3, 0, 7};
    int seq_dn_w[4]    = '{0, 0, 0, 1};

    initial begin
        res8 = 1'b0; en8 = 1'b0; up8 = 1'b0; sat8 = 1'b0; load8 = 1'b0; load_val8 = 8'd0;
        res4 = 1'b0; en4 = 1'b0; up4 = 1'b0; sat4 = 1'b0; load4 = 1'b0; load_val4 = 4'd0;
`ifdef UPDOWN_COUNTER_CAPTURE_EN
        cap8 = 1'b0; cap4 = 1'b0;
`endif

        // Test 1: reset then full-range wrap-up count
        tick();
        chk("rst8_c", c8, 0);
        chk("rst8_wrap", wrap8, 0);
        chk("rst8_tc_down", tc8, 1);
        up8 = 1'b1;
        #1;
        chk("tc8_follows_up", tc8, 0);
        res8 = 1'b1; en8 = 1'b1; sat8 = 1'b0;
        wrap_cnt = 0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk($sformatf("t1_c_%0d", k), c8, k % 256);
            chk($sformatf("t1_wrap_%0d", k), wrap8, (k == 256) ? 1 : 0);
            if (wrap8 === 1'b1) wrap_cnt++;
            if (k == 255) chk("t1_tc_at_max", tc8, 1);
        end
        chk("t1_wrap_count", wrap_cnt, 1);

        // Test 2: step 3, wrap up from 0 within 0..9
        tick();
        chk("rst4_c", c4, 0);
        chk("rst4_wrap", wrap4, 0);
        res4 = 1'b1; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("t2_c_%0d", i), c4, seq_up_c[i]);
            chk($sformatf("t2_wrap_%0d", i), wrap4, seq_up_w[i]);
            if (i == 2) chk("t2_tc_at_9", tc4, 1);
        end

        // Test 3: load 7, saturate down
        load4 = 1'b1; load_val4 = 4'd7; en4 = 1'b0;
        tick();
        chk("t3_load_c", c4, 7);
        chk("t3_load_wrap", wrap4, 0);
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b0; sat4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_c_%0d", i), c4, seq_sat_c[i]);
            chk($sformatf("t3_wrap_%0d", i), wrap4, seq_sat_w[i]);
            chk($sformatf("t3_tc_%0d", i), tc4, seq_sat_tc[i]);
        end

        // Test 4: clamped load wins over enable
        load4 = 1'b1; load_val4 = 4'd15; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
        tick();
        chk("t4_clamp_c", c4, 9);
        chk("t4_clamp_wrap", wrap4, 0);
        load4 = 1'b0; up4 = 1'b0; sat4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4_dn_c_%0d", i), c4, seq_dn_c[i]);
            chk($sformatf("t4_dn_wrap_%0d", i), wrap4, seq_dn_w[i]);
        end
        load4 = 1'b1; load_val4 = 4'd8;
        tick();
        load4 = 1'b0; up4 = 1'b1; sat4 = 1'b1;
        tick();
        chk("t4_satup_c", c4, 9);
        chk("t4_satup_wrap", wrap4, 1);
        tick();
        chk("t4_satup_hold_c", c4, 9);
        chk("t4_satup_hold_wrap", wrap4, 0);
        en4 = 1'b0;
        tick();
        chk("t4_hold_c", c4, 9);
        chk("t4_hold_wrap", wrap4, 0);

        // Test 5: reset beats load and enable mid-count
        load4 = 1'b1; load_val4 = 4'd2; en4 = 1'b0;
        tick();
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
        tick();
        chk("t5_pre_c", c4, 5);
        res4 = 1'b0; load4 = 1'b1; load_val4 = 4'd6;
        tick();
        chk("t5_rst_c", c4, 0);
        chk("t5_rst_wrap", wrap4, 0);
        res4 = 1'b1; load4 = 1'b0;
        tick();
        chk("t5_resume_c0", c4, 3);
        tick();
        chk("t5_resume_c1", c4, 6);

`ifdef UPDOWN_COUNTER_CAPTURE_EN
        // Test 6: capture the pre-update count
        res8 = 1'b0;
        tick();
        chk("t6_rst_cap", cap_val8, 0);
        res8 = 1'b1; en8 = 1'b1; up8 = 1'b1; sat8 = 1'b0;
        repeat (5) tick();
        chk("t6_c_5", c8, 5);
        cap8 = 1'b1;
        tick();
        chk("t6_c_6", c8, 6);
        chk("t6_cap_5", cap_val8, 5);
        cap8 = 1'b0;
        tick();
        tick();
        chk("t6_c_8", c8, 8);
        chk("t6_cap_hold", cap_val8, 5);
        res8 = 1'b0;
        tick();
        chk("t6_cap_rst", cap_val8, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
